// File: rtl/riscv_pkg.sv
// Shared writeback types: data width, register address width, queued result entry.
// Imported by the writeback arbiter, its interface and its result FIFO.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic {
        HOLD_OFF,
        HOLD_ON
    } hold_state_t;

    function automatic logic [31:0] rdOneHot(input logic [REG_ADDR_W-1:0] rd);
        return (rd == '0) ? 32'h0 : (32'h1 << rd);
    endfunction

endpackage

// File: rtl/x_writeback_arbiter_if.sv
// ALU / MDU / regfile-write bundle of the writeback arbiter.
// WB_FWD_EN adds the two operand forwarding lookup ports.
interface x_writeback_arbiter_if;
    import riscv_pkg::*;

    logic                  iALU_VALID;
    logic [REG_ADDR_W-1:0] iALU_RD;
    logic [XLEN-1:0]       iALU_DATA;
    logic                  iMDU_VALID;
    logic                  oMDU_READY;
    logic [REG_ADDR_W-1:0] iMDU_RD;
    logic [XLEN-1:0]       iMDU_DATA;
    logic                  oALU_HOLD;
    logic [REG_ADDR_W-1:0] oWB_RD;
    logic [XLEN-1:0]       oWB_DATA;
    logic [31:0]           oPEND_MASK;
`ifdef WB_FWD_EN
    logic [REG_ADDR_W-1:0] iFWD_RS1;
    logic [REG_ADDR_W-1:0] iFWD_RS2;
    logic                  oFWD_HIT1;
    logic                  oFWD_HIT2;
    logic [XLEN-1:0]       oFWD_DATA1;
    logic [XLEN-1:0]       oFWD_DATA2;

    modport master (
        output iALU_VALID, iALU_RD, iALU_DATA,
        output iMDU_VALID, iMDU_RD, iMDU_DATA,
        output iFWD_RS1, iFWD_RS2,
        input  oMDU_READY, oALU_HOLD,
        input  oWB_RD, oWB_DATA, oPEND_MASK,
        input  oFWD_HIT1, oFWD_HIT2,
        input  oFWD_DATA1, oFWD_DATA2
    );

    modport slave (
        input  iALU_VALID, iALU_RD, iALU_DATA,
        input  iMDU_VALID, iMDU_RD, iMDU_DATA,
        input  iFWD_RS1, iFWD_RS2,
        output oMDU_READY, oALU_HOLD,
        output oWB_RD, oWB_DATA, oPEND_MASK,
        output oFWD_HIT1, oFWD_HIT2,
        output oFWD_DATA1, oFWD_DATA2
    );
`else
    modport master (
        output iALU_VALID, iALU_RD, iALU_DATA,
        output iMDU_VALID, iMDU_RD, iMDU_DATA,
        input  oMDU_READY, oALU_HOLD,
        input  oWB_RD, oWB_DATA, oPEND_MASK
    );

    modport slave (
        input  iALU_VALID, iALU_RD, iALU_DATA,
        input  iMDU_VALID, iMDU_RD, iMDU_DATA,
        output oMDU_READY, oALU_HOLD,
        output oWB_RD, oWB_DATA, oPEND_MASK
    );
`endif

endinterface

// File: rtl/x_writeback_arbiter_fifo.sv
// In-order queue of MDU results waiting for the regfile write port.
// Full/empty come from a separate count; the raw entry array is exposed for scans.
module wb_result_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          push,
    input  wb_entry_t     pushEntry,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    output logic [PW-1:0] rdPtr,
    output wb_entry_t     entries [DEPTH]
);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wrPtr;

    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head    = mem[rdPtr];
    assign entries = mem;

endmodule

// File: rtl/x_writeback_arbiter.sv
// Regfile write-port arbiter: ALU first, MDU results queued, pending-write mask.
// Define WB_FWD_EN to add combinational operand forwarding from queued results.
module x_writeback_arbiter
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input logic                  iCLK,
    input logic                  iRST,
    x_writeback_arbiter_if.slave bus
);

    wb_entry_t     head;
    wb_entry_t     entries [DEPTH];
    wb_entry_t     winner;
    wb_entry_t     wbReg;
    logic [CW-1:0] count;
    logic [CW-1:0] cntNext;
    logic [PW-1:0] rdPtr;
    logic          fifoPush;
    logic          fifoPop;
    logic          full;
    logic          empty;
    logic          mduXfer;
    logic          hold;
    logic          selHold;
    logic          selAlu;
    logic          selHead;
    logic          selByp;
    hold_state_t   holdState;
    hold_state_t   holdNext;

    wb_result_fifo #(.DEPTH(DEPTH)) uFifo (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .push      (fifoPush),
        .pushEntry ({bus.iMDU_RD, bus.iMDU_DATA}),
        .pop       (fifoPop),
        .head      (head),
        .count     (count),
        .rdPtr     (rdPtr),
        .entries   (entries)
    );

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign mduXfer = bus.iMDU_VALID & ~full;

    // One-hot select so the decoder below stays a parallel case.
    assign selHold = hold;
    assign selAlu  = ~hold & bus.iALU_VALID & (bus.iALU_RD != '0);
    assign selHead = ~hold & ~selAlu & ~empty;
    assign selByp  = ~hold & ~selAlu & empty & mduXfer;

    always_comb begin
        winner  = '0;
        fifoPop = 1'b0;
        unique case (1'b1)
            selHold: begin
                fifoPop = ~empty;
                winner  = empty ? '0 : head;
            end
            selAlu: begin
                winner.rd   = bus.iALU_RD;
                winner.data = bus.iALU_DATA;
            end
            selHead: begin
                fifoPop = 1'b1;
                winner  = head;
            end
            selByp: begin
                if (bus.iMDU_RD != '0) begin
                    winner.rd   = bus.iMDU_RD;
                    winner.data = bus.iMDU_DATA;
                end
            end
            default: winner = '0;
        endcase
    end

    assign fifoPush = mduXfer & ~selByp & (bus.iMDU_RD != '0);
    assign cntNext  = count + CW'(fifoPush) - CW'(fifoPop);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wbReg <= '0;
        end else begin
            wbReg <= winner;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            holdState <= HOLD_OFF;
        end else begin
            holdState <= holdNext;
        end
    end

    // Set at full, released only below DEPTH-1 to avoid toggling.
    always_comb begin
        holdNext = holdState;
        unique case (holdState)
            HOLD_OFF: if (cntNext == CW'(DEPTH)) holdNext = HOLD_ON;
            HOLD_ON:  if (cntNext < CW'(DEPTH - 1)) holdNext = HOLD_OFF;
            default:  holdNext = HOLD_OFF;
        endcase
    end

    always_comb begin
        hold = (holdState == HOLD_ON);
    end

    always_comb begin
        bus.oPEND_MASK = rdOneHot(wbReg.rd);
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                bus.oPEND_MASK |= rdOneHot(entries[rdPtr + PW'(i)].rd);
            end
        end
    end

    assign bus.oMDU_READY = ~full;
    assign bus.oALU_HOLD  = hold;
    assign bus.oWB_RD     = wbReg.rd;
    assign bus.oWB_DATA   = wbReg.data;

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the last match wins.
    function automatic logic [XLEN:0] fwdLookup(input logic [REG_ADDR_W-1:0] rs);
        logic            hit;
        logic [XLEN-1:0] data;
        hit  = (rs != '0) && (wbReg.rd == rs);
        data = hit ? wbReg.data : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((rs != '0) && (CW'(i) < count)
                && (entries[rdPtr + PW'(i)].rd == rs)) begin
                hit  = 1'b1;
                data = entries[rdPtr + PW'(i)].data;
            end
        end
        return {hit, data};
    endfunction

    always_comb begin
        {bus.oFWD_HIT1, bus.oFWD_DATA1} = fwdLookup(bus.iFWD_RS1);
        {bus.oFWD_HIT2, bus.oFWD_DATA2} = fwdLookup(bus.iFWD_RS2);
    end
`endif

    aluDuringHold: assert property (
        @(posedge iCLK) disable iff (iRST) !(hold && bus.iALU_VALID)
    );

endmodule

// File: tb/tb_x_writeback_arbiter.sv
// Directed vector bench for x_writeback_arbiter.
// Build with WB_FWD_EN to also check the forwarding lookup.
module tb_x_writeback_arbiter;
    import riscv_pkg::*;

    typedef struct {
        logic        aluV;
        logic [4:0]  aluRd;
        logic [31:0] aluData;
        logic        mduV;
        logic [4:0]  mduRd;
        logic [31:0] mduData;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        logic        ready;
        logic        hold;
        logic [31:0] mask;
        logic        hit1;
        logic [31:0] fd1;
        logic        hit2;
        logic [31:0] fd2;
    } vec_t;

    logic iCLK;
    logic iRST;
    int   nChecks;
    int   nErr;
    vec_t tbl [$];

    x_writeback_arbiter_if bus ();

    x_writeback_arbiter #(.DEPTH(4)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic aV, input logic [4:0] aRd,
                         input logic [31:0] aD, input logic mV,
                         input logic [4:0] mRd, input logic [31:0] mD);
        bus.iALU_VALID = aV;
        bus.iALU_RD    = aRd;
        bus.iALU_DATA  = aD;
        bus.iMDU_VALID = mV;
        bus.iMDU_RD    = mRd;
        bus.iMDU_DATA  = mD;
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chkAll(input string tag, input logic [4:0] rd,
                          input logic [31:0] data, input logic rdy,
                          input logic hld, input logic [31:0] mask);
        chk({tag, " wbRd"}, 32'(bus.oWB_RD), 32'(rd));
        chk({tag, " wbData"}, bus.oWB_DATA, data);
        chk({tag, " ready"}, 32'(bus.oMDU_READY), 32'(rdy));
        chk({tag, " hold"}, 32'(bus.oALU_HOLD), 32'(hld));
        chk({tag, " mask"}, bus.oPEND_MASK, mask);
    endtask

    function automatic void add(
        input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
        input logic mV, input logic [4:0] mRd, input logic [31:0] mD,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic [4:0] eRd, input logic [31:0] eD,
        input logic eRdy, input logic eHld, input logic [31:0] eMask,
        input logic h1, input logic [31:0] d1,
        input logic h2, input logic [31:0] d2);
        vec_t v;
        v.aluV = aV; v.aluRd = aRd; v.aluData = aD;
        v.mduV = mV; v.mduRd = mRd; v.mduData = mD;
        v.rs1 = r1; v.rs2 = r2;
        v.wbRd = eRd; v.wbData = eD;
        v.ready = eRdy; v.hold = eHld; v.mask = eMask;
        v.hit1 = h1; v.fd1 = d1; v.hit2 = h2; v.fd2 = d2;
        tbl.push_back(v);
    endfunction

    initial begin
        nChecks = 0;
        nErr    = 0;
        iRST    = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
`ifdef WB_FWD_EN
        bus.iFWD_RS1 = '0;
        bus.iFWD_RS2 = '0;
`endif

        // single ALU write, then idle
        add(1, 5, 32'hAAAA_0001, 0, 0, 0, 5, 0, 5, 32'hAAAA_0001, 1, 0, 32'h20, 1, 32'hAAAA_0001, 0, 0);
        add(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // MDU bypass with empty queue
        add(0, 0, 0, 1, 7, 32'h1234, 7, 0, 7, 32'h1234, 1, 0, 32'h80, 1, 32'h1234, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // ALU busy while MDU fills the queue
        add(1, 20, 32'h100, 1, 8, 32'h800, 8, 20, 20, 32'h100, 1, 0, 32'h0010_0100, 1, 32'h800, 1, 32'h100);
        add(1, 21, 32'h101, 1, 9, 32'h801, 0, 0, 21, 32'h101, 1, 0, 32'h0020_0300, 0, 0, 0, 0);
        add(1, 22, 32'h102, 1, 10, 32'h802, 0, 0, 22, 32'h102, 1, 0, 32'h0040_0700, 0, 0, 0, 0);
        add(1, 23, 32'h103, 1, 11, 32'h803, 11, 0, 23, 32'h103, 0, 1, 32'h0080_0F00, 1, 32'h803, 0, 0);
        // full: offer from MDU refused, hold keeps ALU off
        add(0, 0, 0, 1, 12, 32'h80C, 12, 8, 8, 32'h800, 1, 1, 32'hF00, 0, 0, 1, 32'h800);
        add(0, 0, 0, 0, 0, 0, 12, 0, 9, 32'h801, 1, 0, 32'hE00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 10, 32'h802, 1, 0, 32'hC00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 11, 32'h803, 1, 0, 32'h800, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // x3 queued behind ALU writes
        add(1, 4, 32'h44, 1, 3, 32'h3333, 3, 4, 4, 32'h44, 1, 0, 32'h18, 1, 32'h3333, 1, 32'h44);
        add(1, 6, 32'h66, 0, 0, 0, 3, 4, 6, 32'h66, 1, 0, 32'h48, 1, 32'h3333, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 0, 3, 32'h3333, 1, 0, 32'h8, 1, 32'h3333, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // two queued writes to x2: youngest must forward
        add(1, 1, 32'h1, 1, 2, 32'h22, 0, 1, 1, 32'h1, 1, 0, 32'h6, 0, 0, 1, 32'h1);
        add(1, 5, 32'h5, 1, 2, 32'h2222, 2, 5, 5, 32'h5, 1, 0, 32'h24, 1, 32'h2222, 1, 32'h5);
        add(0, 0, 0, 0, 0, 0, 2, 0, 2, 32'h22, 1, 0, 32'h4, 1, 32'h2222, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 0, 2, 32'h2222, 1, 0, 32'h4, 1, 32'h2222, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // rd=0 from both sources is dropped
        add(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        tick();
        tick();
        chkAll("reset", 0, 0, 1, 0, 0);
        iRST = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].aluV, tbl[i].aluRd, tbl[i].aluData,
                  tbl[i].mduV, tbl[i].mduRd, tbl[i].mduData);
`ifdef WB_FWD_EN
            bus.iFWD_RS1 = tbl[i].rs1;
            bus.iFWD_RS2 = tbl[i].rs2;
`endif
            tick();
            chkAll($sformatf("row%0d", i), tbl[i].wbRd, tbl[i].wbData,
                   tbl[i].ready, tbl[i].hold, tbl[i].mask);
`ifdef WB_FWD_EN
            chk($sformatf("row%0d hit1", i), 32'(bus.oFWD_HIT1), 32'(tbl[i].hit1));
            chk($sformatf("row%0d fwd1", i), bus.oFWD_DATA1, tbl[i].fd1);
            chk($sformatf("row%0d hit2", i), 32'(bus.oFWD_HIT2), 32'(tbl[i].hit2));
            chk($sformatf("row%0d fwd2", i), bus.oFWD_DATA2, tbl[i].fd2);
`endif
        end

        // reset with three results queued
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(20 + i), 32'(32'h100 + i), 1, 5'(13 + i), 32'(32'hD00 + i));
            tick();
        end
        chkAll("prefill", 22, 32'h102, 1, 0, 32'h0040_E000);
        drive(0, 0, 0, 0, 0, 0);
        iRST = 1'b1;
        tick();
        chkAll("midreset", 0, 0, 1, 0, 0);
        iRST = 1'b0;
        tick();
        chkAll("postreset", 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
